vram_dump: RTL and testbench

- Reader-side counterpart to the VRAM writers (putchar / clear / scroll).
- On a start pulse, walks the whole text VRAM in row-major order, reading one character per address.
- Streams each character, plus end-of-row line terminators, to a byte-wide transmit sink (UART TX) over a valid/ready handshake.
- Sits beside control; takes the shared VRAM port through the same running-based arbitration as the other VRAM masters.

---
 rtl/vram_pkg.sv | 21 ++
 rtl/vram_dump_pos.sv | 40 ++++
 rtl/vram_dump.sv | 141 ++++++++++++++
 tb/tb_vram_dump.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants and FSM state encoding for the VRAM dump reader.
package vram_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int ROW_W       = 5;
  localparam int COL_W       = 6;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_EOL_CR,
    S_EOL_LF,
    S_DONE
  } dump_state_t;

endpackage

// File: rtl/vram_dump_pos.sv
// Row/column position counter for the VRAM dump walk, with last-column and
// last-row flags. Advancing the row also returns the column to zero.
module dump_pos
  import vram_pkg::*;
#(
  parameter int ROWS = 17,
  parameter int COLS = 60
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_advance_col,
  input  logic             i_advance_row,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last_col,
  output logic             o_last_row
);

  logic [ROW_W-1:0] row_reg;
  logic [COL_W-1:0] col_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (i_advance_row) begin
      row_reg <= row_reg + 1'b1;
      col_reg <= '0;
    end else if (i_advance_col) begin
      col_reg <= col_reg + 1'b1;
    end
  end

  assign o_row      = row_reg;
  assign o_col      = col_reg;
  assign o_last_col = (col_reg == COL_W'(COLS - 1));
  assign o_last_row = (row_reg == ROW_W'(ROWS - 1));

endmodule

// File: rtl/vram_dump.sv
// Walks the text VRAM row-major and streams characters plus line terminators
// to a byte sink. Define DUMP_CRLF_EN to end rows with CR LF instead of LF.
module vram_dump
  import vram_pkg::*;
#(
  parameter int COLS = 60,
  parameter int ROWS = 17
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  output logic                   o_running,
  output logic                   o_done,
  output logic [VRAM_ADDR_W-1:0] o_vram_addr,
  output logic                   o_vram_ce,
  output logic                   o_vram_w,
  input  logic [7:0]             i_vram_dout,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready
);

  dump_state_t      state_reg;
  logic             running_reg;
  logic             done_reg;
  logic             ce_reg;
  logic             tx_valid_reg;
  logic [7:0]       tx_data_reg;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col;
  logic             last_row;
  logic             accept;
  logic             pos_clear;
  logic             adv_col;
  logic             adv_row;

  assign accept    = tx_valid_reg && i_tx_ready;
  assign pos_clear = (state_reg == S_IDLE) && i_start;
  assign adv_col   = (state_reg == S_SEND) && accept && !last_col;
  assign adv_row   = (state_reg == S_EOL_LF) && accept && !last_row;

  dump_pos #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pos (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clear       (pos_clear),
    .i_advance_col (adv_col),
    .i_advance_row (adv_row),
    .o_row         (row),
    .o_col         (col),
    .o_last_col    (last_col),
    .o_last_row    (last_row)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= S_IDLE;
      running_reg  <= 1'b0;
      done_reg     <= 1'b0;
      ce_reg       <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= 8'h00;
    end else begin
      done_reg <= 1'b0;
      ce_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (i_start) begin
            state_reg   <= S_READ;
            running_reg <= 1'b1;
            ce_reg      <= 1'b1;
          end
        end
        S_READ: state_reg <= S_WAIT;
        S_WAIT: begin
          tx_data_reg  <= i_vram_dout;
          tx_valid_reg <= 1'b1;
          state_reg    <= S_SEND;
        end
        S_SEND: begin
          if (accept) begin
            if (last_col) begin
`ifdef DUMP_CRLF_EN
              state_reg   <= S_EOL_CR;
              tx_data_reg <= ASCII_CR;
`else
              state_reg   <= S_EOL_LF;
              tx_data_reg <= ASCII_LF;
`endif
            end else begin
              tx_valid_reg <= 1'b0;
              ce_reg       <= 1'b1;
              state_reg    <= S_READ;
            end
          end
        end
        S_EOL_CR: begin
          if (accept) begin
            state_reg   <= S_EOL_LF;
            tx_data_reg <= ASCII_LF;
          end
        end
        S_EOL_LF: begin
          if (accept) begin
            tx_valid_reg <= 1'b0;
            if (last_row) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_READ;
              ce_reg    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_reg   <= S_IDLE;
          running_reg <= 1'b0;
        end
        default: begin
          state_reg    <= S_IDLE;
          running_reg  <= 1'b0;
          tx_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Address comes straight from the position registers; they read 0 after reset.
  assign o_vram_addr = {row, col};
  assign o_vram_ce   = ce_reg;
  assign o_vram_w    = 1'b0;
  assign o_running   = running_reg;
  assign o_done      = done_reg;
  assign o_tx_valid  = tx_valid_reg;
  assign o_tx_data   = tx_data_reg;

endmodule

// File: tb/tb_vram_dump.sv
// Directed bench for vram_dump: a 2x3 screen instance and a default-size one.
module tb_vram_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s_start, s_running, s_done, s_ce, s_w, s_valid, s_ready;
  logic [10:0] s_addr;
  logic [7:0]  s_dout, s_data;
  logic        d_start, d_running, d_done, d_ce, d_w, d_valid, d_ready;
  logic [10:0] d_addr;
  logic [7:0]  d_dout, d_data;

  logic [7:0]  s_mem [0:2047];
  logic [7:0]  d_mem [0:2047];

  logic [7:0]  s_bytes[$];
  logic [7:0]  d_bytes[$];
  logic [10:0] s_reads[$];
  logic [10:0] d_reads[$];
  logic [7:0]  exp_s[$];
  logic [7:0]  exp_d[$];
  int          s_done_cnt = 0;
  int          d_done_cnt = 0;
  logic        w_seen = 1'b0;

  int checks = 0;
  int failures = 0;

  vram_dump #(.COLS(3), .ROWS(2)) u_small (
    .i_clk(clk), .i_rst(rst), .i_start(s_start), .o_running(s_running), .o_done(s_done),
    .o_vram_addr(s_addr), .o_vram_ce(s_ce), .o_vram_w(s_w), .i_vram_dout(s_dout),
    .o_tx_data(s_data), .o_tx_valid(s_valid), .i_tx_ready(s_ready)
  );

  vram_dump u_dflt (
    .i_clk(clk), .i_rst(rst), .i_start(d_start), .o_running(d_running), .o_done(d_done),
    .o_vram_addr(d_addr), .o_vram_ce(d_ce), .o_vram_w(d_w), .i_vram_dout(d_dout),
    .o_tx_data(d_data), .o_tx_valid(d_valid), .i_tx_ready(d_ready)
  );

  always @(posedge clk) begin
    if (s_ce) s_dout <= s_mem[s_addr];
    if (d_ce) d_dout <= d_mem[d_addr];
  end

  always @(negedge clk) begin
    if (s_valid && s_ready) s_bytes.push_back(s_data);
    if (d_valid && d_ready) d_bytes.push_back(d_data);
    if (s_ce) s_reads.push_back(s_addr);
    if (d_ce) d_reads.push_back(d_addr);
    if (s_done) s_done_cnt++;
    if (d_done) d_done_cnt++;
    if (s_w === 1'b1 || d_w === 1'b1) w_seen = 1'b1;
  end

  function automatic int small_diff();
    int e = 0;
    if (s_bytes.size() != exp_s.size()) return 1000;
    foreach (exp_s[i]) if (s_bytes[i] !== exp_s[i]) e++;
    return e;
  endfunction

  task automatic clear_small();
    s_bytes.delete();
    s_reads.delete();
    s_done_cnt = 0;
  endtask

  task automatic pulse_s_start();
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic wait_small_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (s_running && n < budget);
    checks++;
    if (s_running !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout: running=%b after %0d cycles, want 0", name, s_running, n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_start = 1'b1; d_start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_running, s_done, s_ce, s_w, s_valid} !== 5'b0 || s_addr !== 11'd0 || s_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_small: run=%b done=%b ce=%b w=%b valid=%b addr=%h data=%h, want all 0",
               s_running, s_done, s_ce, s_w, s_valid, s_addr, s_data);
    end
    checks++;
    if ({d_running, d_done, d_ce, d_w, d_valid} !== 5'b0 || d_addr !== 11'd0 || d_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_dflt: run=%b done=%b ce=%b w=%b valid=%b addr=%h data=%h, want all 0",
               d_running, d_done, d_ce, d_w, d_valid, d_addr, d_data);
    end
    s_start = 1'b0; d_start = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_running !== 1'b0 || d_running !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: running s=%b d=%b, want 0 0", s_running, d_running);
    end
  endtask

  task automatic test_basic();
    logic [10:0] want_reads [6];
    int bad = 0;
    want_reads = '{11'd0, 11'd1, 11'd2, 11'd64, 11'd65, 11'd66};
    s_ready = 1'b1;
    clear_small();
    pulse_s_start();
    @(negedge clk);
    checks++;
    if (s_ce !== 1'b1 || s_valid !== 1'b0 || s_running !== 1'b1) begin
      failures++;
      $display("FAIL basic_read_cycle: ce=%b valid=%b run=%b, want 1 0 1", s_ce, s_valid, s_running);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || s_ce !== 1'b0) begin
      failures++;
      $display("FAIL basic_wait_cycle: valid=%b ce=%b, want 0 0", s_valid, s_ce);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b1 || s_data !== 8'h41) begin
      failures++;
      $display("FAIL basic_first_byte: valid=%b data=%h, want 1 41", s_valid, s_data);
    end
    wait_small_idle(200, "basic");
    checks++;
    if (small_diff() != 0) begin
      failures++;
      $display("FAIL basic_seq: diff=%0d got_len=%0d want_len=%0d", small_diff(), s_bytes.size(), exp_s.size());
    end
    checks++;
    if (s_done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done: pulses=%0d, want 1", s_done_cnt);
    end
    if (s_reads.size() != 6) bad = 100;
    else foreach (want_reads[i]) if (s_reads[i] !== want_reads[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL basic_reads: bad=%0d count=%0d, want 0 bad of 6", bad, s_reads.size());
    end
    $display("basic dump: %0d bytes, %0d reads, %0d done", s_bytes.size(), s_reads.size(), s_done_cnt);
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    int n = 0;
    int a1 = 0;
    s_ready = 1'b1;
    clear_small();
    pulse_s_start();
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (!s_running) break;
      if (s_valid && s_data == 8'h42 && stalls < 5) begin
        s_ready = 1'b0;
        stalls++;
      end else begin
        s_ready = 1'b1;
      end
    end
    s_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (stalls != 5) begin
      failures++;
      $display("FAIL bp_hold: stall cycles with valid=1 data=42 = %0d, want 5", stalls);
    end
    foreach (s_reads[i]) if (s_reads[i] == 11'd1) a1++;
    checks++;
    if (a1 != 1 || s_reads.size() != 6) begin
      failures++;
      $display("FAIL bp_reads: reads_of_addr1=%0d total=%0d, want 1 6", a1, s_reads.size());
    end
    checks++;
    if (small_diff() != 0) begin
      failures++;
      $display("FAIL bp_seq: diff=%0d got_len=%0d want_len=%0d", small_diff(), s_bytes.size(), exp_s.size());
    end
    $display("backpressure dump: %0d stall cycles, %0d bytes", stalls, s_bytes.size());
  endtask

  task automatic test_restart_ignored();
    int n = 0;
    s_ready = 1'b1;
    clear_small();
    pulse_s_start();
    while (s_bytes.size() < 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    wait_small_idle(200, "restart");
    repeat (5) @(negedge clk);
    checks++;
    if (small_diff() != 0) begin
      failures++;
      $display("FAIL restart_seq: diff=%0d got_len=%0d want_len=%0d", small_diff(), s_bytes.size(), exp_s.size());
    end
    checks++;
    if (s_done_cnt != 1 || s_running !== 1'b0) begin
      failures++;
      $display("FAIL restart_done: pulses=%0d running=%b, want 1 0", s_done_cnt, s_running);
    end
    $display("restart dump: %0d bytes, %0d done", s_bytes.size(), s_done_cnt);
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int held;
    s_ready = 1'b1;
    clear_small();
    pulse_s_start();
    while (!(s_valid && s_data == 8'h79) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(s_valid && s_data == 8'h79)) begin
      failures++;
      $display("FAIL midrst_reach: valid=%b data=%h, want 1 79", s_valid, s_data);
    end
    rst = 1'b1; s_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_running, s_done, s_ce, s_w, s_valid} !== 5'b0 || s_addr !== 11'd0 || s_data !== 8'h00) begin
      failures++;
      $display("FAIL midrst_outputs: run=%b done=%b ce=%b w=%b valid=%b addr=%h data=%h, want all 0",
               s_running, s_done, s_ce, s_w, s_valid, s_addr, s_data);
    end
    rst = 1'b0; s_ready = 1'b1;
    held = s_bytes.size();
    repeat (10) @(negedge clk);
    checks++;
    if (s_bytes.size() != held || s_running !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: bytes %0d->%0d running=%b, want no change and 0", held, s_bytes.size(), s_running);
    end
    clear_small();
    pulse_s_start();
    wait_small_idle(200, "midrst_rerun");
    checks++;
    if (small_diff() != 0 || s_reads.size() == 0 || s_reads[0] !== 11'd0) begin
      failures++;
      $display("FAIL midrst_rerun: diff=%0d first_read=%h, want 0 000",
               small_diff(), (s_reads.size() != 0) ? s_reads[0] : 11'h7ff);
    end
    $display("mid-reset rerun: %0d bytes", s_bytes.size());
  endtask

  task automatic test_default_size();
    int n = 0;
    int bad = 0;
    d_ready = 1'b1;
    d_bytes.delete(); d_reads.delete(); d_done_cnt = 0;
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (d_running && n < 8000);
    checks++;
    if (d_running !== 1'b0) begin
      failures++;
      $display("FAIL dflt_timeout: running=%b after %0d cycles, want 0", d_running, n);
    end
    repeat (3) @(negedge clk);
    if (d_bytes.size() != exp_d.size()) bad = 100000;
    else foreach (exp_d[i]) if (d_bytes[i] !== exp_d[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL dflt_seq: bad=%0d got_len=%0d want_len=%0d", bad, d_bytes.size(), exp_d.size());
    end
    checks++;
    if (d_reads.size() != 1020 || d_reads[d_reads.size()-1] !== 11'd1083) begin
      failures++;
      $display("FAIL dflt_reads: count=%0d last=%0d, want 1020 1083", d_reads.size(),
               (d_reads.size() != 0) ? d_reads[d_reads.size()-1] : 11'd0);
    end
    checks++;
    if (w_seen !== 1'b0 || d_done_cnt != 1) begin
      failures++;
      $display("FAIL dflt_misc: w_seen=%b done=%0d, want 0 1", w_seen, d_done_cnt);
    end
    $display("default dump: %0d bytes in %0d cycles", d_bytes.size(), n);
  endtask

  initial begin
    s_start = 1'b0; d_start = 1'b0; s_ready = 1'b1; d_ready = 1'b1;
    s_dout = 8'h00; d_dout = 8'h00;
    for (int a = 0; a < 2048; a++) begin
      s_mem[a] = 8'h2E;
      d_mem[a] = 8'(a * 7 + 1);
    end
    s_mem[0] = 8'h41; s_mem[1] = 8'h42; s_mem[2] = 8'h43;
    s_mem[64] = 8'h78; s_mem[65] = 8'h79; s_mem[66] = 8'h7A;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) exp_s.push_back(s_mem[r * 64 + c]);
`ifdef DUMP_CRLF_EN
      exp_s.push_back(8'h0D);
`endif
      exp_s.push_back(8'h0A);
    end
    for (int r = 0; r < 17; r++) begin
      for (int c = 0; c < 60; c++) exp_d.push_back(d_mem[r * 64 + c]);
`ifdef DUMP_CRLF_EN
      exp_d.push_back(8'h0D);
`endif
      exp_d.push_back(8'h0A);
    end

    test_reset();
    test_basic();
    test_backpressure();
    test_restart_ignored();
    test_mid_reset();
    test_default_size();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
